// File: rtl/lcd_hd44780_pkg.sv
// ----------------------------------------------------------------------------
// lcd_hd44780_pkg
// Shared definitions for the HD44780 4-bit-mode controller:
//   - controller state enum
//   - power-up initialisation ROM (entry kind, value, wait select, count)
//   - command constants and small helper functions
// ----------------------------------------------------------------------------
package lcd_hd44780_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP   = 3'd0,
    ST_INIT    = 3'd1,
    ST_IDLE    = 3'd2,
    ST_XFER_HI = 3'd3,
    ST_XFER_LO = 3'd4,
    ST_WAIT    = 3'd5
  } lcd_state_e;

  // A ROM entry is either a lone nibble (value[3:0]) or a full byte.
  typedef enum logic {
    ENT_NIBBLE = 1'b0,
    ENT_BYTE   = 1'b1
  } init_kind_e;

  typedef enum logic {
    WSEL_CMD  = 1'b0,
    WSEL_LONG = 1'b1
  } wait_sel_e;

  typedef struct packed {
    init_kind_e kind;
    logic [7:0] value;
    wait_sel_e  wsel;
  } init_entry_t;

  localparam int         INIT_LEN  = 8;
  localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // 4-bit wake-up sequence: three 0x3 nibbles (the first needs the long
  // delay), switch to 4-bit with 0x2, then function set / display on /
  // entry mode / clear. Clear needs the long delay as well.
  function automatic init_entry_t init_rom(input logic [2:0] idx);
    init_entry_t e;
    case (idx)
      3'd0:    e = '{ENT_NIBBLE, 8'h03, WSEL_LONG};
      3'd1:    e = '{ENT_NIBBLE, 8'h03, WSEL_CMD};
      3'd2:    e = '{ENT_NIBBLE, 8'h03, WSEL_CMD};
      3'd3:    e = '{ENT_NIBBLE, 8'h02, WSEL_CMD};
      3'd4:    e = '{ENT_BYTE,   8'h28, WSEL_CMD};
      3'd5:    e = '{ENT_BYTE,   8'h0C, WSEL_CMD};
      3'd6:    e = '{ENT_BYTE,   8'h06, WSEL_CMD};
      default: e = '{ENT_BYTE,   CMD_CLEAR, WSEL_LONG};
    endcase
    return e;
  endfunction

  // Clear (0x01) and return-home (0x02/0x03, bit 0 is don't-care) are the
  // slow instructions on the panel.
  function automatic logic needs_long_wait(input logic rs, input logic [7:0] d);
    return !rs && ((d == CMD_CLEAR) || (d == CMD_HOME) || (d == 8'h03));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_hd44780_nibble_tx.sv
// ----------------------------------------------------------------------------
// lcd_nibble_tx
// Drives one E-strobed nibble onto the LCD bus:
//   SETUP_CYCLES with E low, E_CYCLES with E high, SETUP_CYCLES hold with E low.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           launch a nibble (accepted in any phase; restarts the strobe)
//   nibble, rs      value presented on lcd_d / lcd_rs from the start edge
//   lcd_d, lcd_rs   registered bus outputs, held after the strobe completes
//   lcd_e           registered enable strobe
//   done            1-cycle pulse during the last hold cycle, so the caller
//                   can start the next nibble on the following edge with no gap
//   dbg_phase       current strobe phase
// ----------------------------------------------------------------------------
module lcd_nibble_tx #(
  parameter int SETUP_CYCLES = 2,
  parameter int E_CYCLES     = 5,
  parameter int CW           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nibble,
  input  logic       rs,
  output logic [3:0] lcd_d,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic       done,
  output logic [1:0] dbg_phase
);

  localparam logic [1:0] PH_OFF    = 2'd0;
  localparam logic [1:0] PH_SETUP  = 2'd1;
  localparam logic [1:0] PH_STROBE = 2'd2;
  localparam logic [1:0] PH_HOLD   = 2'd3;

  logic [1:0]    r_phase;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_d;
  logic          r_rs;
  logic          r_e;

  assign done      = (r_phase == PH_HOLD) && (r_cnt == '0);
  assign lcd_d     = r_d;
  assign lcd_rs    = r_rs;
  assign lcd_e     = r_e;
  assign dbg_phase = r_phase;

  // Each phase loads its length minus one on entry and leaves when the
  // counter reaches zero, so a phase lasts exactly its parameter in clocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase <= PH_OFF;
      r_cnt   <= '0;
      r_d     <= '0;
      r_rs    <= 1'b0;
      r_e     <= 1'b0;
    end else if (start) begin
      r_phase <= PH_SETUP;
      r_cnt   <= CW'(SETUP_CYCLES - 1);
      r_d     <= nibble;
      r_rs    <= rs;
      r_e     <= 1'b0;
    end else begin
      case (r_phase)
        PH_SETUP: begin
          if (r_cnt == '0) begin
            r_phase <= PH_STROBE;
            r_cnt   <= CW'(E_CYCLES - 1);
            r_e     <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        PH_STROBE: begin
          if (r_cnt == '0) begin
            r_phase <= PH_HOLD;
            r_cnt   <= CW'(SETUP_CYCLES - 1);
            r_e     <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        PH_HOLD: begin
          if (r_cnt == '0) begin
            r_phase <= PH_OFF;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_phase <= PH_OFF;
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// ----------------------------------------------------------------------------
// lcd_hd44780_ctrl
// HD44780 character-LCD controller, 4-bit bus mode, write-only (R/W tied low).
// After reset: waits PWRUP_WAIT clocks, plays the init ROM, raises init_done,
// then accepts command/data bytes and sends each as high then low nibble,
// followed by a fixed execution wait.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   in_valid       byte offered
//   in_ready       controller can take a byte (only in IDLE)
//   in_rs, in_data register select (0 cmd / 1 data) and byte
//   lcd_d          DB7..DB4
//   lcd_rs, lcd_e  register select and enable strobe
//   init_done      high once initialisation has completed
//   dbg_state      current controller state (lcd_state_e encoding)
//
// Handshake: a byte transfers on a rising clk edge where in_valid and in_ready
// are both 1. in_ready is registered and is 1 only while idle; it drops on the
// transfer edge. in_rs/in_data are captured on that edge and not looked at
// again. in_valid may stay high across transfers to stream bytes.
//
// Wait timing: the IDLE cycle that precedes an acceptance counts as the last
// cycle of the previous wait, so consecutive acceptances are exactly
// 2*N + W clocks apart (N = 2*SETUP_CYCLES + E_CYCLES). The init ROM uses the
// same rule, the INIT launch cycle taking the place of the IDLE cycle. Waits
// (and PWRUP_WAIT) must therefore be at least 2.
// ----------------------------------------------------------------------------
module lcd_hd44780_ctrl
  import lcd_hd44780_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int E_CYCLES     = 5,
  parameter int CMD_WAIT     = 500,
  parameter int LONG_WAIT    = 20000,
  parameter int PWRUP_WAIT   = 150000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic [3:0] lcd_d,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic       init_done,
  output logic [2:0] dbg_state
);

  localparam int MAX_P = max_int(max_int(max_int(SETUP_CYCLES, E_CYCLES),
                                         max_int(CMD_WAIT, LONG_WAIT)),
                                 PWRUP_WAIT);
  localparam int CW = $clog2(MAX_P) + 1;

  lcd_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_data;
  logic          r_rs;
  logic          r_long;
  logic          r_in_ready;
  logic          r_init_done;

  init_entry_t   w_entry;
  logic          w_accept;
  logic          w_start;
  logic [3:0]    w_nibble;
  logic          w_nib_rs;
  logic          w_done;
  logic [CW-1:0] w_wait_load;
  logic [1:0]    w_tx_phase;

  assign in_ready  = r_in_ready;
  assign init_done = r_init_done;
  assign dbg_state = r_state;

  assign w_wait_load = r_long ? CW'(LONG_WAIT - 2) : CW'(CMD_WAIT - 2);

  always_comb begin
    w_entry  = init_rom(r_idx);
    w_accept = (r_state == ST_IDLE) && r_in_ready && in_valid;
    w_start  = 1'b0;
    w_nibble = '0;
    w_nib_rs = 1'b0;
    case (r_state)
      ST_INIT: begin
        // A lone init nibble goes out as if it were the low half of a byte,
        // so it flows straight into WAIT after one strobe.
        w_start  = 1'b1;
        w_nibble = (w_entry.kind == ENT_NIBBLE) ? w_entry.value[3:0]
                                                : w_entry.value[7:4];
      end
      ST_IDLE: begin
        if (w_accept) begin
          w_start  = 1'b1;
          w_nibble = in_data[7:4];
          w_nib_rs = in_rs;
        end
      end
      ST_XFER_HI: begin
        if (w_done) begin
          w_start  = 1'b1;
          w_nibble = r_data[3:0];
          w_nib_rs = r_rs;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_PWRUP;
      r_cnt       <= CW'(PWRUP_WAIT - 2);
      r_idx       <= '0;
      r_data      <= '0;
      r_rs        <= 1'b0;
      r_long      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_PWRUP: begin
          if (r_cnt == '0) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_INIT: begin
          r_data  <= w_entry.value;
          r_rs    <= 1'b0;
          r_long  <= (w_entry.wsel == WSEL_LONG);
          r_state <= (w_entry.kind == ENT_NIBBLE) ? ST_XFER_LO : ST_XFER_HI;
        end
        ST_IDLE: begin
          if (w_accept) begin
            r_data     <= in_data;
            r_rs       <= in_rs;
            r_long     <= needs_long_wait(in_rs, in_data);
            r_in_ready <= 1'b0;
            r_state    <= ST_XFER_HI;
          end
        end
        ST_XFER_HI: begin
          if (w_done) begin
            r_state <= ST_XFER_LO;
          end
        end
        ST_XFER_LO: begin
          if (w_done) begin
            r_state <= ST_WAIT;
            r_cnt   <= w_wait_load;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            if (r_init_done || (r_idx == INIT_LAST)) begin
              r_state     <= ST_IDLE;
              r_in_ready  <= 1'b1;
              r_init_done <= 1'b1;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= ST_INIT;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= ST_PWRUP;
          r_cnt   <= CW'(PWRUP_WAIT - 2);
        end
      endcase
    end
  end

  lcd_nibble_tx #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .E_CYCLES     (E_CYCLES),
    .CW           (CW)
  ) u_nibble_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_start),
    .nibble    (w_nibble),
    .rs        (w_nib_rs),
    .lcd_d     (lcd_d),
    .lcd_rs    (lcd_rs),
    .lcd_e     (lcd_e),
    .done      (w_done),
    .dbg_phase (w_tx_phase)
  );

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lcd_hd44780_ctrl
// Self-checking bench for lcd_hd44780_ctrl with short timing parameters.
// The reference model is the panel-side view: the list of {rs,nibble} values
// seen at each E rise, E pulse widths, and the spacing between acceptances
// (2*N + selected wait per byte).
// ----------------------------------------------------------------------------
module tb_lcd_hd44780_ctrl;

  localparam int S_CYC  = 1;
  localparam int E_CYC  = 2;
  localparam int C_WAIT = 4;
  localparam int L_WAIT = 8;
  localparam int P_WAIT = 10;
  localparam int N_CYC  = 2 * S_CYC + E_CYC;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic [3:0] lcd_d;
  logic       lcd_rs;
  logic       lcd_e;
  logic       init_done;
  logic [2:0] dbg_state;

  lcd_hd44780_ctrl #(
    .SETUP_CYCLES (S_CYC),
    .E_CYCLES     (E_CYC),
    .CMD_WAIT     (C_WAIT),
    .LONG_WAIT    (L_WAIT),
    .PWRUP_WAIT   (P_WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs     (in_rs),
    .in_data   (in_data),
    .lcd_d     (lcd_d),
    .lcd_rs    (lcd_rs),
    .lcd_e     (lcd_e),
    .init_done (init_done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q[$];
  logic [4:0] seen_q[$];
  int         rise_q[$];
  int         width_q[$];
  int         early_cnt = 0;
  logic       mon_prev_e = 1'b0;
  int         mon_w = 0;

  // Bus monitor, sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (lcd_e && !mon_prev_e) begin
      seen_q.push_back({lcd_rs, lcd_d});
      rise_q.push_back(cyc);
      mon_w = 0;
    end
    if (lcd_e) mon_w++;
    if (!lcd_e && mon_prev_e) width_q.push_back(mon_w);
    if (in_ready && !init_done) early_cnt++;
    mon_prev_e = lcd_e;
  end

  // ---------------- reference model ----------------
  function automatic int byte_latency(input logic rs, input logic [7:0] d);
    int w;
    w = (!rs && (d >= 8'h01) && (d <= 8'h03)) ? L_WAIT : C_WAIT;
    return 2 * N_CYC + w;
  endfunction

  function automatic void push_byte(input logic rs, input logic [7:0] d);
    exp_q.push_back({rs, d[7:4]});
    exp_q.push_back({rs, d[3:0]});
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_nibble_count"}, seen_q.size(), exp_q.size());
    check({tag, "_pulse_count"}, width_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
      check($sformatf("%s_nib%0d", tag, i), seen_q[i], exp_q[i]);
    for (int i = 0; i < width_q.size(); i++)
      check($sformatf("%s_ewidth%0d", tag, i), width_q[i], E_CYC);
    seen_q.delete();
    exp_q.delete();
    rise_q.delete();
    width_q.delete();
  endtask

  // Wait (bounded) for in_ready at a falling edge.
  task automatic wait_ready(output bit ok);
    int k;
    k = 0;
    while (!in_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    ok = in_ready;
  endtask

  // ---------------- driver tasks ----------------
  task automatic reset_and_init();
    int rel;
    int k;
    int init_total;
    int init_n[8];
    int init_w[8];
    init_n = '{1, 1, 1, 1, 2, 2, 2, 2};
    init_w = '{L_WAIT, C_WAIT, C_WAIT, C_WAIT, C_WAIT, C_WAIT, C_WAIT, L_WAIT};
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lcd_e", lcd_e, 0);
    check("rst_lcd_d", lcd_d, 0);
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_init_done", init_done, 0);
    seen_q.delete();
    exp_q.delete();
    rise_q.delete();
    width_q.delete();
    early_cnt = 0;
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h02);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h01);
    init_total = 0;
    for (int i = 0; i < 8; i++) init_total += init_n[i] * N_CYC + init_w[i];
    // Offer a byte throughout initialisation; it must not be taken.
    rel      = cyc;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = 8'hAA;
    k = 0;
    while (seen_q.size() < 8 && k < 500) begin
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    check("init_first_rise", (rise_q.size() > 0) ? (rise_q[0] - rel) : -1,
          P_WAIT + S_CYC);
    k = 0;
    while (!init_done && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("init_done_edge", init_done ? (cyc + 1 - rel) : 0, P_WAIT + init_total);
    check("init_ready", in_ready, 1);
    check("ready_before_init", early_cnt, 0);
    check_stream("init");
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] d, input bit corrupt);
    bit ok;
    int t0;
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    wait_ready(ok);
    check("accept_timeout", ok, 1);
    if (ok) begin
      t0 = cyc + 1;
      push_byte(rs, d);
      @(negedge clk);
      in_valid = 1'b0;
      if (corrupt) begin
        in_data = 8'hFF;
        in_rs   = ~rs;
      end
      check("hi_nibble", lcd_d, d[7:4]);
      check("hi_rs", lcd_rs, rs);
      check("hi_e_low", lcd_e, 0);
      check("ready_drop", in_ready, 0);
      repeat (N_CYC) @(negedge clk);
      check("lo_nibble", lcd_d, d[3:0]);
      check("lo_rs", lcd_rs, rs);
      wait_ready(ok);
      check("ready_latency", ok ? (cyc + 1 - t0) : 0, byte_latency(rs, d));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  logic [7:0] b2b_bytes[3];
  int         t_acc[3];
  bit         ok_v;
  logic       r_rs_v;
  logic [7:0] r_d_v;
  int         k_v;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_rs    = 1'b0;
    in_data  = 8'h00;
    b2b_bytes = '{8'h41, 8'h42, 8'h43};

    reset_and_init();

    send_byte(1'b1, 8'h48, 1'b0);
    send_byte(1'b0, 8'h01, 1'b0);
    send_byte(1'b0, 8'h80, 1'b0);
    send_byte(1'b0, 8'h02, 1'b0);
    check_stream("basic");

    // Streamed bytes with in_valid held high.
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = b2b_bytes[0];
    for (int b = 0; b < 3; b++) begin
      wait_ready(ok_v);
      check("b2b_accept", ok_v, 1);
      t_acc[b] = cyc + 1;
      push_byte(1'b1, b2b_bytes[b]);
      @(negedge clk);
      if (b < 2) in_data = b2b_bytes[b + 1];
      else in_valid = 1'b0;
    end
    check("b2b_gap1", t_acc[1] - t_acc[0], byte_latency(1'b1, b2b_bytes[0]));
    check("b2b_gap2", t_acc[2] - t_acc[1], byte_latency(1'b1, b2b_bytes[1]));
    wait_ready(ok_v);
    check("b2b_final_ready", ok_v, 1);
    check_stream("b2b");

    // Inputs changed right after acceptance must not matter.
    send_byte(1'b1, 8'h35, 1'b1);
    check_stream("latch");

    for (int i = 0; i < 10; i++) begin
      r_rs_v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) r_d_v = 8'($urandom_range(0, 3));
      else r_d_v = 8'($urandom_range(0, 255));
      send_byte(r_rs_v, r_d_v, 1'($urandom_range(0, 1)));
    end
    check_stream("rand");

    // Reset while E is high.
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = 8'h5A;
    wait_ready(ok_v);
    check("mid_accept", ok_v, 1);
    @(negedge clk);
    in_valid = 1'b0;
    k_v = 0;
    while (!lcd_e && k_v < 50) begin
      @(negedge clk);
      k_v++;
    end
    check("mid_e_seen", lcd_e, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_e_low", lcd_e, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_init_done", init_done, 0);
    reset_and_init();

    send_byte(1'b1, 8'hC3, 1'b0);
    check_stream("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
